mem_port_arbiter: RTL and testbench

- Shares the single-port word-addressed data/instruction memory between two requesters: the instruction-fetch stage (I port, read-only) and the load/store stage (D port, read/write).
- Sits between the pipeline and the memory; owns the memory's address, write-data, write-enable and read-enable inputs.
- Each access takes a grant cycle and a memory cycle; read data is registered and returned with a one-cycle ack pulse.
- The pipeline stalls a stage while its req is high and ack is low.

---
 rtl/mem_port_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port (instruction fetch / load-store) arbiter in front of a single-port word memory.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise D has fixed priority over I.
module mem_port_arbiter #(
   parameter int WIDTH      = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int DEPTH      = 63
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  i_req,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   output logic                  i_ack,
   output logic [WIDTH-1:0]      i_rdata,
   output logic                  i_err,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [WIDTH-1:0]      d_wdata,
   output logic                  d_ack,
   output logic [WIDTH-1:0]      d_rdata,
   output logic                  d_err,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0]      mem_wdata,
   output logic                  mem_we,
   output logic                  mem_re,
   input  logic [WIDTH-1:0]      mem_rdata,
   output logic                  busy
);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] lat_addr;
   logic [WIDTH-1:0]      lat_wdata;
   logic                  lat_we;
   logic                  lat_id;      // 1 = D port, 0 = I port
   logic                  i_elig, d_elig, grant_any, grant_d;
   logic                  in_range;
   logic [WIDTH-1:0]      rd_val;

   // A port still showing req during its own ack cycle is not a new request.
   assign i_elig    = i_req & ~i_ack;
   assign d_elig    = d_req & ~d_ack;
   assign grant_any = i_elig | d_elig;

`ifdef MEM_ARB_RR_EN
   logic last_d;

   assign grant_d = d_elig & (~i_elig | ~last_d);

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         last_d <= 1'b1;
      else if (state == IDLE && grant_any)
         last_d <= grant_d;
   end
`else
   assign grant_d = d_elig;
`endif

   assign in_range = (lat_addr < ADDR_WIDTH'(DEPTH));
   assign rd_val   = (in_range && !lat_we) ? mem_rdata : '0;

   assign busy      = (state == ACCESS);
   assign mem_addr  = lat_addr;
   assign mem_wdata = lat_wdata;
   assign mem_we    = busy & in_range & lat_we;
   assign mem_re    = busy & in_range & ~lat_we;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_any) state_nxt = ACCESS;
         ACCESS:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Grant latch in IDLE, completion (ack/err/rdata) at the end of ACCESS.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_we    <= 1'b0;
         lat_id    <= 1'b0;
         i_ack     <= 1'b0;
         i_err     <= 1'b0;
         i_rdata   <= '0;
         d_ack     <= 1'b0;
         d_err     <= 1'b0;
         d_rdata   <= '0;
      end else begin
         i_ack <= 1'b0;
         i_err <= 1'b0;
         d_ack <= 1'b0;
         d_err <= 1'b0;
         if (state == IDLE && grant_any) begin
            lat_id    <= grant_d;
            lat_addr  <= grant_d ? d_addr : i_addr;
            lat_we    <= grant_d & d_we;
            lat_wdata <= grant_d ? d_wdata : '0;
         end
         if (state == ACCESS) begin
            if (lat_id) begin
               d_ack   <= 1'b1;
               d_err   <= ~in_range;
               d_rdata <= rd_val;
            end else begin
               i_ack   <= 1'b1;
               i_err   <= ~in_range;
               i_rdata <= rd_val;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 63-word memory.
module tb_mem_port_arbiter;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        i_req = 1'b0;
   logic [31:0] i_addr = '0;
   logic        i_ack;
   logic [31:0] i_rdata;
   logic        i_err;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic        d_err;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic        mem_re;
   logic [31:0] mem_rdata;
   logic        busy;

   logic [31:0] mem [0:62];
   int nvec = 0;
   int nerr = 0;

   mem_port_arbiter #(.WIDTH(32), .ADDR_WIDTH(32), .DEPTH(63)) dut (
      .clock(clock), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clock = ~clock;

   assign mem_rdata = (mem_addr < 32'd63) ? mem[mem_addr[5:0]] : 32'h0;

   always @(posedge clock)
      if (mem_we && mem_addr < 32'd63) mem[mem_addr[5:0]] <= mem_wdata;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #3;
      nvec++;
      if ({i_ack, d_ack, i_err, d_err, mem_we, mem_re, busy} !== 7'b0) begin
         nerr++;
         $display("FAIL reset_ctl: got %b required 0000000", {i_ack, d_ack, i_err, d_err, mem_we, mem_re, busy});
      end
      nvec++;
      if ({i_rdata, d_rdata, mem_addr, mem_wdata} !== 128'b0) begin
         nerr++;
         $display("FAIL reset_data: got %h required 0", {i_rdata, d_rdata, mem_addr, mem_wdata});
      end
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_simultaneous();
      int ik = 0, dk = 0;
      logic [31:0] ird = '0, drd = '0;
      i_addr = 32'd3; d_addr = 32'd4; d_we = 1'b0;
      i_req = 1'b1; d_req = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (d_ack && dk == 0) begin dk = k; drd = d_rdata; d_req = 1'b0; end
         if (i_ack && ik == 0) begin ik = k; ird = i_rdata; i_req = 1'b0; end
      end
`ifdef MEM_ARB_RR_EN
      nvec++; if (ik !== 2) begin nerr++; $display("FAIL sim_i_ack_cycle: got %0d required 2", ik); end
      nvec++; if (dk !== 4) begin nerr++; $display("FAIL sim_d_ack_cycle: got %0d required 4", dk); end
`else
      nvec++; if (dk !== 2) begin nerr++; $display("FAIL sim_d_ack_cycle: got %0d required 2", dk); end
      nvec++; if (ik !== 4) begin nerr++; $display("FAIL sim_i_ack_cycle: got %0d required 4", ik); end
`endif
      nvec++; if (ird !== 32'h11) begin nerr++; $display("FAIL sim_i_rdata: got %h required 00000011", ird); end
      nvec++; if (drd !== 32'h44) begin nerr++; $display("FAIL sim_d_rdata: got %h required 00000044", drd); end
   endtask

   task automatic test_store_load();
      int dk = 0, wcnt = 0;
      logic derr = 1'b1;
      logic [31:0] drd = '0;
      d_we = 1'b1; d_addr = 32'd5; d_wdata = 32'hDEADBEEF; d_req = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (mem_we) wcnt++;
         if (d_ack && dk == 0) begin dk = k; d_req = 1'b0; end
      end
      nvec++; if (wcnt !== 1) begin nerr++; $display("FAIL store_we_cycles: got %0d required 1", wcnt); end
      nvec++; if (dk !== 2) begin nerr++; $display("FAIL store_ack_cycle: got %0d required 2", dk); end
      nvec++; if (mem[5] !== 32'hDEADBEEF) begin nerr++; $display("FAIL store_mem: got %h required deadbeef", mem[5]); end
      dk = 0;
      d_we = 1'b0; d_req = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (d_ack && dk == 0) begin dk = k; drd = d_rdata; derr = d_err; d_req = 1'b0; end
      end
      nvec++; if (dk !== 2) begin nerr++; $display("FAIL load_ack_cycle: got %0d required 2", dk); end
      nvec++; if (drd !== 32'hDEADBEEF) begin nerr++; $display("FAIL load_rdata: got %h required deadbeef", drd); end
      nvec++; if (derr !== 1'b0) begin nerr++; $display("FAIL load_err: got %b required 0", derr); end
      nvec++; if (d_rdata !== 32'hDEADBEEF) begin nerr++; $display("FAIL load_rdata_hold: got %h required deadbeef", d_rdata); end
   endtask

   task automatic test_out_of_range();
      int dk = 0, ik = 0, wcnt = 0;
      logic derr = 1'b0, ierr = 1'b0;
      logic [31:0] drd = 32'hFFFFFFFF, ird = 32'hFFFFFFFF;
      d_we = 1'b1; d_addr = 32'd63; d_wdata = 32'h12345678; d_req = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (mem_we) wcnt++;
         if (d_ack && dk == 0) begin dk = k; drd = d_rdata; derr = d_err; d_req = 1'b0; end
      end
      nvec++; if (wcnt !== 0) begin nerr++; $display("FAIL oor_we_cycles: got %0d required 0", wcnt); end
      nvec++; if (dk !== 2) begin nerr++; $display("FAIL oor_ack_cycle: got %0d required 2", dk); end
      nvec++; if (derr !== 1'b1) begin nerr++; $display("FAIL oor_err: got %b required 1", derr); end
      nvec++; if (drd !== 32'h0) begin nerr++; $display("FAIL oor_rdata: got %h required 0", drd); end
      nvec++; if (d_err !== 1'b0) begin nerr++; $display("FAIL oor_err_pulse: got %b required 0", d_err); end
      nvec++; if (mem[5] !== 32'hDEADBEEF) begin nerr++; $display("FAIL oor_mem_intact: got %h required deadbeef", mem[5]); end
      i_addr = 32'd200; i_req = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (i_ack && ik == 0) begin ik = k; ird = i_rdata; ierr = i_err; i_req = 1'b0; end
      end
      nvec++; if (ik !== 2) begin nerr++; $display("FAIL oor_i_ack_cycle: got %0d required 2", ik); end
      nvec++; if ({ierr, ird} !== {1'b1, 32'h0}) begin nerr++; $display("FAIL oor_i_err_rdata: got %b/%h required 1/0", ierr, ird); end
   endtask

   task automatic test_back_to_back();
      int last = -1, ilast = 0, dlast = 0, icnt = 0, dcnt = 0;
      i_addr = 32'd3; d_addr = 32'd4; d_we = 1'b0;
      i_req = 1'b1; d_req = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         nvec++;
         if (i_ack && d_ack) begin nerr++; $display("FAIL b2b_both_ack: edge %0d got 1/1 required one port", k); end
         if (d_ack) begin
            dcnt++;
            nvec++; if (last == 1) begin nerr++; $display("FAIL b2b_alternate: edge %0d got D after D required I", k); end
            nvec++; if (k - dlast > 4) begin nerr++; $display("FAIL b2b_d_wait: got %0d required <=4", k - dlast); end
            nvec++; if (d_rdata !== 32'h44) begin nerr++; $display("FAIL b2b_d_rdata: got %h required 00000044", d_rdata); end
            last = 1; dlast = k;
         end
         if (i_ack) begin
            icnt++;
            nvec++; if (last == 0) begin nerr++; $display("FAIL b2b_alternate: edge %0d got I after I required D", k); end
            nvec++; if (k - ilast > 4) begin nerr++; $display("FAIL b2b_i_wait: got %0d required <=4", k - ilast); end
            nvec++; if (i_rdata !== 32'h11) begin nerr++; $display("FAIL b2b_i_rdata: got %h required 00000011", i_rdata); end
            last = 0; ilast = k;
         end
      end
      nvec++; if (icnt < 4 || dcnt < 4) begin nerr++; $display("FAIL b2b_counts: got I=%0d D=%0d required >=4 each", icnt, dcnt); end
      i_req = 1'b0; d_req = 1'b0;
      tick(); tick(); tick();
   endtask

   task automatic test_reset_mid();
      int dk = 0, acks = 0;
      logic [31:0] drd = 32'hFFFFFFFF;
      d_we = 1'b1; d_addr = 32'd7; d_wdata = 32'hCAFEF00D; d_req = 1'b1;
      tick();
      nvec++; if ({busy, mem_we} !== 2'b11) begin nerr++; $display("FAIL rmid_access: got %b required 11", {busy, mem_we}); end
      #2 reset = 1'b1;
      #1;
      nvec++;
      if ({i_ack, d_ack, i_err, d_err, mem_we, mem_re, busy, i_rdata, d_rdata, mem_addr, mem_wdata} !== '0) begin
         nerr++;
         $display("FAIL rmid_outputs: got busy=%b we=%b addr=%h wdata=%h required all 0", busy, mem_we, mem_addr, mem_wdata);
      end
      d_req = 1'b0;
      @(posedge clock);
      #2 reset = 1'b0;
      for (int k = 0; k < 4; k++) begin tick(); if (d_ack) acks++; end
      nvec++; if (acks !== 0) begin nerr++; $display("FAIL rmid_no_ack: got %0d required 0", acks); end
      nvec++; if (mem[7] !== 32'h0) begin nerr++; $display("FAIL rmid_mem: got %h required 0", mem[7]); end
      d_we = 1'b0; d_req = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (d_ack && dk == 0) begin dk = k; drd = d_rdata; d_req = 1'b0; end
      end
      nvec++; if (dk !== 2) begin nerr++; $display("FAIL rmid_load_ack: got %0d required 2", dk); end
      nvec++; if (drd !== 32'h0) begin nerr++; $display("FAIL rmid_load_rdata: got %h required 0", drd); end
   endtask

   initial begin
      for (int a = 0; a < 63; a++) mem[a] = 32'h0;
      mem[3] = 32'h11;
      mem[4] = 32'h44;
      test_reset();
      test_simultaneous();
      test_store_load();
      test_out_of_range();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
